// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared widths, update kinds and saturating-counter helpers
package branch_predictor_pkg;
  localparam int XLEN = 32;
  localparam int CTR_MAX_W = 8;
  typedef logic [CTR_MAX_W-1:0] ctr_t;
  typedef enum logic [1:0] {UPD_NONE, UPD_HIT, UPD_ALLOC} upd_kind_e;
  function automatic ctr_t ctr_max(input int w);
    return ctr_t'((1 << w) - 1);
  endfunction
  function automatic ctr_t ctr_weak_taken(input int w);
    return ctr_t'(1 << (w - 1));
  endfunction
  function automatic ctr_t ctr_sat_inc(input ctr_t c, input int w);
    return (c == ctr_max(w)) ? c : c + ctr_t'(1);
  endfunction
  function automatic ctr_t ctr_sat_dec(input ctr_t c);
    return (c == '0) ? c : c - ctr_t'(1);
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: fetch lookup, execute update and statistics signals
interface branch_predictor_if import branch_predictor_pkg::*; #(
  parameter int XLEN = branch_predictor_pkg::XLEN,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0] lookup_pc;
  logic pred_taken;
  logic [XLEN-1:0] pred_target;
  logic pred_hit;
  logic upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic upd_taken;
  logic [XLEN-1:0] upd_target;
  logic upd_is_jump;
  logic upd_mispredict;
  logic flush_all;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;
  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispredict, flush_all,
    input pred_taken, pred_target, pred_hit, stat_updates, stat_mispredicts
  );
  modport slave (
    input lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispredict, flush_all,
    output pred_taken, pred_target, pred_hit, stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: next value of one prediction counter for a hit or an allocation
module bp_sat_counter import branch_predictor_pkg::*; #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  upd_kind_e        kind_i,
  input  logic             jump_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);
  ctr_t cur, nxt;
  always_comb begin
    cur = ctr_t'(ctr_i);
    nxt = jump_i ? ctr_max(CTR_W) :
          kind_i == UPD_ALLOC ? ctr_weak_taken(CTR_W) :
          taken_i ? ctr_sat_inc(cur, CTR_W) : ctr_sat_dec(cur);
    ctr_o = CTR_W'(nxt);
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating counters, combinational lookup
// and registered update from the execute stage.
module branch_predictor import branch_predictor_pkg::*; #(
  parameter int XLEN = branch_predictor_pkg::XLEN,
  parameter int ENTRIES = 64,
  parameter int CTR_W = 2,
  parameter int STAT_W = 32
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  logic [ENTRIES-1:0] valid_q;
  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [XLEN-1:0] tgt_q [ENTRIES];
  logic [STAT_W-1:0] upd_cnt_q, upd_cnt_d, mis_cnt_q, mis_cnt_d;
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic [CTR_W-1:0] ctr_d;
  logic l_hit, u_hit, tgt_we, unused_pc_lsb;
  upd_kind_e kind;
  assign l_idx = bp.lookup_pc[IDX_W+1:2];
  assign l_tag = bp.lookup_pc[XLEN-1:IDX_W+2];
  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsb = ^bp.upd_pc[1:0];
  // Lookup reads the current table only; an update in this cycle is not forwarded
  assign l_hit = valid_q[l_idx] && tag_q[l_idx] == l_tag;
  assign bp.pred_hit = l_hit;
  assign bp.pred_taken = l_hit && ctr_q[l_idx][CTR_W-1];
  assign bp.pred_target = l_hit ? tgt_q[l_idx] : bp.lookup_pc + XLEN'(4);
  assign bp.stat_updates = upd_cnt_q;
  assign bp.stat_mispredicts = mis_cnt_q;
  always_comb begin
    u_hit = valid_q[u_idx] && tag_q[u_idx] == u_tag;
    kind = (!bp.upd_valid || bp.flush_all) ? UPD_NONE : u_hit ? UPD_HIT : bp.upd_taken ? UPD_ALLOC : UPD_NONE;
    tgt_we = kind == UPD_ALLOC || (kind == UPD_HIT && (bp.upd_taken || bp.upd_is_jump));
    upd_cnt_d = upd_cnt_q + STAT_W'(bp.upd_valid);
    mis_cnt_d = mis_cnt_q + STAT_W'(bp.upd_valid && bp.upd_mispredict);
  end
  bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
    .ctr_i(ctr_q[u_idx]),
    .kind_i(kind),
    .jump_i(bp.upd_is_jump),
    .taken_i(bp.upd_taken),
    .ctr_o(ctr_d)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_W'(ctr_weak_taken(CTR_W) - ctr_t'(1));
      upd_cnt_q <= '0;
      mis_cnt_q <= '0;
    end else begin
      upd_cnt_q <= upd_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      if (bp.flush_all) valid_q <= '0;
      else if (kind == UPD_ALLOC) valid_q[u_idx] <= 1'b1;
      if (kind != UPD_NONE) ctr_q[u_idx] <= ctr_d;
    end
  // Tags and targets carry no reset; writes are still held off while rst is high
  always_ff @(posedge clk)
    if (!rst) begin
      if (kind == UPD_ALLOC) tag_q[u_idx] <= u_tag;
      if (tgt_we) tgt_q[u_idx] <= bp.upd_target;
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed scoreboard bench for branch_predictor
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  branch_predictor_if #(.XLEN(32), .STAT_W(4)) bp();
  branch_predictor #(.XLEN(32), .ENTRIES(64), .CTR_W(2), .STAT_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bp(bp.slave)
  );
  typedef struct { string name; logic [31:0] val; } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  logic [3:0] m_upd, m_mis;

  task automatic push(input string name, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=0x%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.name, obs, e.val);
      end
    end
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tgt);
    bp.lookup_pc = pc;
    push({nm, "_hit"}, 32'(h));
    push({nm, "_taken"}, 32'(t));
    push({nm, "_target"}, tgt);
    #1;
    pop_cmp(32'(bp.pred_hit));
    pop_cmp(32'(bp.pred_taken));
    pop_cmp(bp.pred_target);
  endtask

  task automatic stats(input string nm);
    push({nm, "_updates"}, 32'(m_upd));
    push({nm, "_mispredicts"}, 32'(m_mis));
    #1;
    pop_cmp(32'(bp.stat_updates));
    pop_cmp(32'(bp.stat_mispredicts));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic jmp, input logic mis, input logic flush);
    bp.upd_valid = 1'b1;
    bp.upd_pc = pc;
    bp.upd_taken = taken;
    bp.upd_target = tgt;
    bp.upd_is_jump = jmp;
    bp.upd_mispredict = mis;
    bp.flush_all = flush;
  endtask

  task automatic finish_upd;
    tick;
    m_upd = m_upd + 4'd1;
    if (bp.upd_mispredict) m_mis = m_mis + 4'd1;
    bp.upd_valid = 1'b0;
    bp.flush_all = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic jmp, input logic mis, input logic flush);
    drive(pc, taken, tgt, jmp, mis, flush);
    finish_upd;
  endtask

  initial begin
    bp.lookup_pc = '0;
    bp.upd_valid = 1'b0;
    bp.upd_pc = '0;
    bp.upd_taken = 1'b0;
    bp.upd_target = '0;
    bp.upd_is_jump = 1'b0;
    bp.upd_mispredict = 1'b0;
    bp.flush_all = 1'b0;
    m_upd = '0;
    m_mis = '0;
    #1 rst = 1'b1;
    look("rst_lookup", 32'h100, 1'b0, 1'b0, 32'h104);
    stats("rst_stats");
    tick;
    tick;
    rst = 1'b0;
    look("post_rst", 32'h100, 1'b0, 1'b0, 32'h104);
    drive(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    look("same_cycle", 32'h100, 1'b0, 1'b0, 32'h104);
    finish_upd;
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    stats("alloc_stats");
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    look("nt1", 32'h100, 1'b1, 1'b0, 32'h80);
    repeat (3) upd(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    look("nt_sat", 32'h100, 1'b1, 1'b0, 32'h80);
    upd(32'h100, 1'b1, 32'h90, 1'b0, 1'b1, 1'b0);
    look("t1", 32'h100, 1'b1, 1'b0, 32'h90);
    upd(32'h100, 1'b1, 32'h90, 1'b0, 1'b0, 1'b0);
    look("t2", 32'h100, 1'b1, 1'b1, 32'h90);
    upd(32'h304, 1'b1, 32'h44, 1'b1, 1'b0, 1'b0);
    look("jmp_alloc", 32'h304, 1'b1, 1'b1, 32'h44);
    upd(32'h304, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    look("jmp_dec", 32'h304, 1'b1, 1'b1, 32'h44);
    upd(32'h408, 1'b0, 32'h70, 1'b0, 1'b0, 1'b0);
    look("nt_miss", 32'h408, 1'b0, 1'b0, 32'h40c);
    upd(32'h200, 1'b1, 32'ha0, 1'b0, 1'b0, 1'b0);
    look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("alias_new", 32'h200, 1'b1, 1'b1, 32'ha0);
    look("pc_lsb", 32'h202, 1'b1, 1'b1, 32'ha0);
    stats("mid_stats");
    upd(32'h500, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1);
    look("flush_a", 32'h200, 1'b0, 1'b0, 32'h204);
    look("flush_b", 32'h304, 1'b0, 1'b0, 32'h308);
    look("flush_drop", 32'h500, 1'b0, 1'b0, 32'h504);
    stats("flush_stats");
    rst = 1'b1;
    m_upd = '0;
    m_mis = '0;
    tick;
    rst = 1'b0;
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 1'b1);
    look("flush2", 32'h100, 1'b0, 1'b0, 32'h104);
    push("flush2_updates", 32'd1);
    pop_cmp(32'(bp.stat_updates));
    push("flush2_mispredicts", 32'd1);
    pop_cmp(32'(bp.stat_mispredicts));
    for (int i = 0; i < 15; i++) upd(32'h1000 + 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    upd(32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 1'b0);
    push("wrap_updates", 32'd1);
    pop_cmp(32'(bp.stat_updates));
    stats("wrap_stats");
    look("wrap_alloc", 32'h100, 1'b1, 1'b1, 32'h80);
    drive(32'h600, 1'b1, 32'h60, 1'b0, 1'b1, 1'b0);
    #1 rst = 1'b1;
    m_upd = '0;
    m_mis = '0;
    look("rst_mid_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("rst_mid_new", 32'h600, 1'b0, 1'b0, 32'h604);
    stats("rst_mid_stats");
    tick;
    rst = 1'b0;
    bp.upd_valid = 1'b0;
    look("rst_discard", 32'h600, 1'b0, 1'b0, 32'h604);
    tick;
    look("rst_discard_late", 32'h600, 1'b0, 1'b0, 32'h604);
    stats("rst_discard_stats");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
